// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit: FSM state
// encoding, opcode field bounds and the sequential PC increment.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_t;

    localparam int OPCODE_HI = 31;
    localparam int OPCODE_LO = 21;
    localparam int PC_INCR   = 4;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: sequential increment or word-scaled
// branch offset relative to the presented instruction's address.
import fetch_pkg::*;

module next_pc_calc #(
    parameter int IMEM_AW = 64
) (
    input  logic [IMEM_AW-1:0] i_cur_pc,
    input  logic               i_branch,
    input  logic               i_uncond,
    input  logic               i_zero,
    input  logic [IMEM_AW-1:0] i_imm,
    output logic [IMEM_AW-1:0] o_next_pc
);

    logic               w_taken;
    logic [IMEM_AW-1:0] w_seq_pc;
    logic [IMEM_AW-1:0] w_tgt_pc;

    assign w_taken  = i_uncond | (i_branch & i_zero);
    // Both sums wrap silently at the address width.
    assign w_seq_pc = i_cur_pc + IMEM_AW'(PC_INCR);
    assign w_tgt_pc = i_cur_pc + (i_imm << 2);

    assign o_next_pc = w_taken ? w_tgt_pc : w_seq_pc;

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch FSM (REQ -> ISSUE -> REQ).
// Optional misalignment trap enabled by defining FETCH_ALIGN_CHECK_EN.
import fetch_pkg::*;

module fetch_unit #(
    parameter int               IMEM_AW  = 64,
    parameter logic [IMEM_AW-1:0] RESET_PC = '0
) (
    input  logic               CLK,
    input  logic               Reset_L,
    output logic               IMemReq,
    output logic [IMEM_AW-1:0] IMemAddr,
    input  logic               IMemValid,
    input  logic [31:0]        IMemData,
    output logic [31:0]        Instruction,
    output logic [10:0]        Opcode,
    output logic [IMEM_AW-1:0] CurrentPC,
    output logic               InstrValid,
    input  logic               InstrAccept,
    input  logic               Branch,
    input  logic               Uncondbranch,
    input  logic               Zero,
    input  logic [IMEM_AW-1:0] BranchImm,
    output logic               Fault
);

    fetch_state_t       r_state;
    fetch_state_t       w_state_next;
    logic [IMEM_AW-1:0] r_pc;
    logic [IMEM_AW-1:0] r_cur_pc;
    logic [31:0]        r_instr;
    logic [IMEM_AW-1:0] w_next_pc;
    logic               w_capture;
    logic               w_retire;
    logic               w_misalign;

    next_pc_calc #(
        .IMEM_AW (IMEM_AW)
    ) u_next_pc (
        .i_cur_pc  (r_cur_pc),
        .i_branch  (Branch),
        .i_uncond  (Uncondbranch),
        .i_zero    (Zero),
        .i_imm     (BranchImm),
        .o_next_pc (w_next_pc)
    );

`ifdef FETCH_ALIGN_CHECK_EN
    assign w_misalign = (w_next_pc[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            r_state <= ST_REQ;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        IMemReq      = 1'b0;
        InstrValid   = 1'b0;
        w_capture    = 1'b0;
        w_retire     = 1'b0;
        case (r_state)
            ST_REQ: begin
                IMemReq = 1'b1;
                if (IMemValid) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                InstrValid = 1'b1;
                if (InstrAccept) begin
                    w_retire     = 1'b1;
                    w_state_next = w_misalign ? ST_HALT : ST_REQ;
                end
            end
            ST_HALT: begin
                w_state_next = ST_HALT;
            end
            default: begin
                w_state_next = ST_REQ;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            r_pc     <= RESET_PC;
            r_cur_pc <= '0;
            r_instr  <= '0;
        end else begin
            if (w_capture) begin
                r_instr  <= IMemData;
                r_cur_pc <= r_pc;
            end
            if (w_retire) begin
                r_pc <= w_next_pc;
            end
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    logic r_fault;

    // Sticky until reset; the FSM parks in HALT alongside it.
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            r_fault <= 1'b0;
        end else if (w_retire && w_misalign) begin
            r_fault <= 1'b1;
        end
    end

    assign Fault = r_fault;
`else
    assign Fault = 1'b0;
`endif

    assign IMemAddr    = r_pc;
    assign CurrentPC   = r_cur_pc;
    assign Instruction = r_instr;
    assign Opcode      = r_instr[OPCODE_HI:OPCODE_LO];

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus pushes expected fetch addresses,
// a monitor pops and compares each presented instruction.
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        Reset_L = 1'b0;
    logic        IMemReq;
    logic [63:0] IMemAddr;
    logic        IMemValid = 1'b0;
    logic [31:0] IMemData = '0;
    logic [31:0] Instruction;
    logic [10:0] Opcode;
    logic [63:0] CurrentPC;
    logic        InstrValid;
    logic        InstrAccept = 1'b0;
    logic        Branch = 1'b0;
    logic        Uncondbranch = 1'b0;
    logic        Zero = 1'b0;
    logic [63:0] BranchImm = '0;
    logic        Fault;

    logic        rst2_n = 1'b0;
    logic        req2;
    logic [63:0] addr2;
    logic        ivalid2 = 1'b0;
    logic [31:0] data2 = '0;
    logic [31:0] instr2;
    logic [10:0] opc2;
    logic [63:0] cpc2;
    logic        valid2;
    logic        acc2 = 1'b0;
    logic        fault2;

    int checks = 0;
    int failures = 0;
    int served = 0;
    int presented = 0;
    bit mon_en = 1'b0;
    logic [63:0] model_pc;
    logic [63:0] exp_q[$];

    always #5 CLK = ~CLK;

    fetch_unit #(.IMEM_AW(64), .RESET_PC(64'h0)) u_dut (
        .CLK(CLK), .Reset_L(Reset_L), .IMemReq(IMemReq), .IMemAddr(IMemAddr),
        .IMemValid(IMemValid), .IMemData(IMemData), .Instruction(Instruction),
        .Opcode(Opcode), .CurrentPC(CurrentPC), .InstrValid(InstrValid),
        .InstrAccept(InstrAccept), .Branch(Branch), .Uncondbranch(Uncondbranch),
        .Zero(Zero), .BranchImm(BranchImm), .Fault(Fault)
    );

    fetch_unit #(.IMEM_AW(64), .RESET_PC(64'h2)) u_dut2 (
        .CLK(CLK), .Reset_L(rst2_n), .IMemReq(req2), .IMemAddr(addr2),
        .IMemValid(ivalid2), .IMemData(data2), .Instruction(instr2),
        .Opcode(opc2), .CurrentPC(cpc2), .InstrValid(valid2),
        .InstrAccept(acc2), .Branch(1'b0), .Uncondbranch(1'b0),
        .Zero(1'b0), .BranchImm(64'h0), .Fault(fault2)
    );

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (a == 64'h0) return 32'h8B020020;
        return (a[31:0] * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Memory response after 'delay' idle REQ cycles; junk on the decode side is ignored.
    task automatic serve(input int delay);
        for (int i = 0; i < delay; i++) begin
            @(negedge CLK);
            IMemValid    = 1'b0;
            IMemData     = $urandom;
            InstrAccept  = 1'($urandom);
            Uncondbranch = 1'($urandom);
        end
        @(negedge CLK);
        IMemValid   = 1'b1;
        IMemData    = mem_word(IMemAddr);
        InstrAccept = 1'($urandom);
        served++;
        @(posedge CLK);
        #1;
        chk("valid_after_resp", 64'(InstrValid), 64'd1);
    endtask

    // Retire the presented instruction after 'hold' withheld cycles.
    task automatic accept(input int hold, input bit b, input bit u, input bit z,
                          input logic [63:0] imm);
        for (int i = 0; i < hold; i++) begin
            @(negedge CLK);
            InstrAccept  = 1'b0;
            IMemValid    = 1'b1;
            IMemData     = $urandom;
            Uncondbranch = 1'($urandom);
        end
        @(negedge CLK);
        IMemValid    = 1'($urandom);
        IMemData     = $urandom;
        InstrAccept  = 1'b1;
        Branch       = b;
        Uncondbranch = u;
        Zero         = z;
        BranchImm    = imm;
        if (u || (b && z)) model_pc = model_pc + (imm << 2);
        else               model_pc = model_pc + 64'd4;
        exp_q.push_back(model_pc);
        @(posedge CLK);
        #1;
        chk("req_after_accept", 64'(IMemReq), 64'd1);
    endtask

    task automatic pulse_reset(input bit late_valid);
        @(negedge CLK);
        IMemValid   = 1'b0;
        InstrAccept = 1'b0;
        #2 Reset_L = 1'b0;
        #1;
        chk("rst_req", 64'(IMemReq), 64'd1);
        chk("rst_addr", IMemAddr, 64'h0);
        chk("rst_valid", 64'(InstrValid), 64'd0);
        chk("rst_instr", 64'(Instruction), 64'd0);
        chk("rst_curpc", CurrentPC, 64'h0);
        chk("rst_fault", 64'(Fault), 64'd0);
        exp_q.delete();
        model_pc = 64'h0;
        exp_q.push_back(model_pc);
        if (late_valid) begin
            IMemValid = 1'b1;
            IMemData  = mem_word(64'h0);
            served++;
        end
        #1 Reset_L = 1'b1;
        if (late_valid) begin
            @(posedge CLK);
            #1;
            chk("late_valid_capture", 64'(InstrValid), 64'd1);
        end
    endtask

    // Monitor: one sample per cycle, just after the active edge.
    initial begin
        bit          prev_v = 1'b0;
        logic [63:0] held_pc = '0;
        logic [31:0] held_instr = '0;
        forever begin
            @(posedge CLK);
            #1;
            if (mon_en) begin
                if (InstrValid && !prev_v) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_instr actual_pc=%h required=none", CurrentPC);
                    end else begin
                        held_pc    = exp_q.pop_front();
                        held_instr = mem_word(held_pc);
                        presented++;
                        chk("cur_pc", CurrentPC, held_pc);
                        chk("instr", 64'(Instruction), 64'(held_instr));
                        chk("opcode", 64'(Opcode), 64'(held_instr[31:21]));
                        $display("txn pc=%h instr=%h opcode=%h", CurrentPC, Instruction, Opcode);
                    end
                end else if (InstrValid) begin
                    chk("hold_pc", CurrentPC, held_pc);
                    chk("hold_instr", 64'(Instruction), 64'(held_instr));
                end
                if (IMemReq) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_req actual_addr=%h required=none", IMemAddr);
                    end else begin
                        chk("imem_addr", IMemAddr, exp_q[0]);
                    end
                end
                chk("req_xor_valid", 64'(IMemReq ^ InstrValid), 64'd1);
                chk("fault_zero", 64'(Fault), 64'd0);
                prev_v = InstrValid;
            end
        end
    end

    initial begin
        model_pc = 64'h0;
        exp_q.push_back(model_pc);
        @(negedge CLK);
        #1;
        chk("init_valid", 64'(InstrValid), 64'd0);
        chk("init_instr", 64'(Instruction), 64'd0);
        chk("init_req", 64'(IMemReq), 64'd1);
        @(negedge CLK);
        Reset_L = 1'b1;
        mon_en  = 1'b1;
        #1;
        chk("first_req", 64'(IMemReq), 64'd1);
        chk("first_addr", IMemAddr, 64'h0);

        serve(0);
        chk("first_opcode", 64'(Opcode), 64'h458);
        chk("first_curpc", CurrentPC, 64'h0);
        for (int i = 0; i < 4; i++) begin
            accept(0, 0, 0, 0, 64'h0);
            serve(0);
        end
        accept(0, 0, 1, 0, -64'sd2);
        chk("uncond_target", IMemAddr, 64'd8);
        serve(0);
        accept(0, 0, 0, 0, 64'h0);
        serve(0);
        accept(0, 0, 0, 0, 64'h0);
        serve(0);
        accept(0, 1, 0, 0, 64'd5);
        chk("not_taken_seq", IMemAddr, 64'd20);

        serve(5);
        accept(3, 0, 0, 0, 64'h0);

        pulse_reset(1'b1);
        accept(0, 1, 1, 1, 64'd3);
        serve(1);
        pulse_reset(1'b0);
        serve(0);
        accept(0, 0, 0, 0, 64'h0);

        for (int n = 0; n < 40; n++) begin
            logic [63:0] imm;
            imm = 64'($urandom_range(0, 15)) - 64'd8;
            serve(int'($urandom_range(0, 3)));
            accept(int'($urandom_range(0, 2)), 1'($urandom), 1'($urandom),
                   1'($urandom), imm);
        end
        @(negedge CLK);
        IMemValid   = 1'b0;
        InstrAccept = 1'b0;
        repeat (3) @(negedge CLK);
        chk("served_vs_presented", 64'(presented), 64'(served));
        chk("pending_fetches", 64'(exp_q.size()), 64'd1);

        @(negedge CLK);
        rst2_n = 1'b1;
        #1;
        chk("d2_reset_addr", addr2, 64'h2);
        @(negedge CLK);
        ivalid2 = 1'b1;
        data2   = 32'h1234_5678;
        @(posedge CLK);
        #1;
        chk("d2_valid", 64'(valid2), 64'd1);
        chk("d2_curpc", cpc2, 64'h2);
        @(negedge CLK);
        ivalid2 = 1'b0;
        acc2    = 1'b1;
        @(posedge CLK);
        #1;
`ifdef FETCH_ALIGN_CHECK_EN
        for (int i = 0; i < 3; i++) begin
            chk("d2_fault", 64'(fault2), 64'd1);
            chk("d2_halt_req", 64'(req2), 64'd0);
            chk("d2_halt_valid", 64'(valid2), 64'd0);
            @(negedge CLK);
            ivalid2 = 1'b1;
            @(posedge CLK);
            #1;
        end
`else
        chk("d2_next_addr", addr2, 64'h6);
        chk("d2_fault", 64'(fault2), 64'd0);
        chk("d2_req", 64'(req2), 64'd1);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 64'h0, SHALL set the PC value loaded on reset.
REQ-002 Parameter IMEM_AW, default 64, SHALL set the width of IMemAddr and all PC registers.
REQ-003 CLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Reset_L  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 IMemReq  output  1  SHALL be the fetch request to instruction memory.
REQ-006 IMemAddr  output  IMEM_AW  SHALL be the byte address of the requested word.
REQ-007 IMemValid  input  1  SHALL indicate that IMemData is valid for the outstanding request.
REQ-008 IMemData  input  32  SHALL be the returned instruction word.
REQ-009 Instruction  output  32  SHALL be the held instruction presented to decode.
REQ-010 Opcode  output  11  SHALL equal Instruction[31:21], feeding the single-cycle control decoder.
REQ-011 CurrentPC  output  IMEM_AW  SHALL be the address of the presented Instruction.
REQ-012 InstrValid  output  1  SHALL indicate that Instruction, Opcode and CurrentPC are valid.
REQ-013 InstrAccept  input  1  SHALL indicate that downstream retires the presented instruction this cycle.
REQ-014 Branch, Uncondbranch, Zero  input  1 each  SHALL be the decoder/ALU branch outcome for the presented instruction.
REQ-015 BranchImm  input  IMEM_AW  SHALL be the sign-extended word offset of the presented instruction.
REQ-016 Fault  output  1  SHALL be the sticky misalignment fault flag (see Configuration).

Function
REQ-017 The FSM SHALL have states REQ (IMemReq=1), ISSUE (InstrValid=1) and HALT (nothing asserted).
REQ-018 In REQ, IMemAddr SHALL equal PC; a rising edge with IMemValid=1 SHALL capture IMemData into Instruction, CurrentPC<=PC, and move to ISSUE.
REQ-019 Memory latency SHALL be unbounded; REQ SHALL hold IMemReq and IMemAddr stable until IMemValid.
REQ-020 IMemValid outside REQ SHALL be ignored.
REQ-021 In ISSUE, Instruction and CurrentPC SHALL stay stable until a rising edge with InstrAccept=1, which SHALL update PC and return the FSM to REQ.
REQ-022 InstrAccept outside ISSUE SHALL be ignored.
REQ-023 Taken = Uncondbranch | (Branch & Zero), sampled only on the accept edge; both branch inputs high SHALL count as taken.
REQ-024 Next PC SHALL be CurrentPC + (BranchImm << 2) when taken, otherwise CurrentPC + 4, computed modulo 2^IMEM_AW with silent wrap-around.
REQ-025 Minimum throughput SHALL be one instruction per 2 cycles: IMemValid in the REQ cycle and InstrAccept in the first ISSUE cycle.

Reset
REQ-026 Reset_L=0 SHALL immediately force state=REQ, PC=RESET_PC, Instruction=0, CurrentPC=0, InstrValid=0 and Fault=0.
REQ-027 IMemReq SHALL follow the FSM after reset: it is 1 in the first post-reset cycle, with IMemAddr=RESET_PC.
REQ-028 Reset during an outstanding request SHALL abandon that request; a late IMemValid SHALL be treated as the response to the new request.

Configuration
REQ-029 With FETCH_ALIGN_CHECK_EN defined, a next PC with bits [1:0]!=0 SHALL, on the accept edge, set Fault=1 and move the FSM to HALT, which is exited only by reset.
REQ-030 Without FETCH_ALIGN_CHECK_EN, Fault SHALL be tied to 0, HALT SHALL be unreachable, and misaligned addresses SHALL be issued unchanged.

Structure
REQ-031 Package fetch_pkg SHALL hold the FSM state typedef, the opcode field bounds (31, 21) and the PC increment constant (4).
REQ-032 The next-PC adder and mux SHALL be the sub-module next_pc_calc (purely combinational); the FSM and registers SHALL remain in fetch_unit.

Verification
REQ-033 Reset release with RESET_PC=0 -> IMemReq=1, IMemAddr=0 in the first cycle; IMemValid=1 with IMemData=32'h8B020020 -> next cycle InstrValid=1, Opcode=11'h458, CurrentPC=0.
REQ-034 Sequential stream with zero-wait memory and InstrAccept always 1 -> addresses 0, 4, 8, 12, one instruction every 2 cycles.
REQ-035 Accept at CurrentPC=16 with Uncondbranch=1, BranchImm=-2 -> next IMemAddr=8; Branch=1 with Zero=0 and BranchImm=5 -> next IMemAddr=20.
REQ-036 IMemValid delayed 5 cycles, then InstrAccept withheld 3 cycles -> IMemAddr, Instruction and CurrentPC held stable throughout; no duplicate or lost fetch.
REQ-037 Reset_L pulsed low mid-REQ and mid-ISSUE -> outputs reach reset values asynchronously and fetch restarts at RESET_PC.
REQ-038 With FETCH_ALIGN_CHECK_EN defined, set RESET_PC=2 and accept the first instruction -> Fault=1, IMemReq=0 held until reset; without the macro -> next IMemAddr=6 and Fault=0.
